// File: rtl/conv_window_accum.sv
// K x K tap window filled one column per write; completing write launches a 3-stage adder tree
// (taps + bias, then ReLU/saturate). Result strobes 3 cycles after fire; no backpressure, never stalls.
module conv_window_accum #(
   parameter int DW = 16,
   parameter int K  = 3,
   parameter int OW = 16,
   parameter int CW = $clog2(K)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [CW-1:0]   in_col,
   input  logic [K*DW-1:0] in_data,
   input  logic            in_last,
   input  logic            flush,
   input  logic [OW-1:0]   bias,
   input  logic            relu_en,
   input  logic            sat_en,
   output logic            out_valid,
   output logic [OW-1:0]   out_data,
   output logic            out_last,
   output logic            out_ovf,
   output logic            col_err
);
   localparam int RW = DW + CW + 1;
   localparam int SW = DW + 2*CW + 2;
   localparam int AW = ((SW > OW) ? SW : OW) + 1;

   logic [DW-1:0] tap_q [K][K];
   logic [K-1:0]  mask_q, mask_d, mask_wr, mask_set;
   logic          last_pend_q, last_pend_d, last_set;
   logic          wr_legal, fire;
   logic          col_err_q;

   // ------------------------------------------------------------------
   // Column write / completion detection
   // ------------------------------------------------------------------
   assign wr_legal = in_valid && ({1'b0, in_col} < (CW+1)'(K));

   always_comb begin
      mask_wr = '0;
      for (int c = 0; c < K; c++)
         if (wr_legal && in_col == CW'(c)) mask_wr[c] = 1'b1;
   end

   // Flush clears first; a write in the same cycle then sets its own bit.
   assign mask_set    = (mask_q & {K{~flush}}) | mask_wr;
   assign last_set    = (last_pend_q & ~flush) | (wr_legal & in_last);
   assign fire        = wr_legal & (&mask_set);
   assign mask_d      = fire ? '0 : mask_set;
   assign last_pend_d = last_set & ~fire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_q      <= '0;
         last_pend_q <= 1'b0;
         col_err_q   <= 1'b0;
      end else begin
         mask_q      <= mask_d;
         last_pend_q <= last_pend_d;
         col_err_q   <= in_valid & ~wr_legal;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
               tap_q[r][c] <= '0;
      end else begin
         for (int c = 0; c < K; c++)
            if (mask_wr[c])
               for (int r = 0; r < K; r++)
                  tap_q[r][c] <= in_data[r*DW +: DW];
      end
   end

   // ------------------------------------------------------------------
   // Fire capture: per-window controls travel alongside the sums
   // ------------------------------------------------------------------
   logic          fire_q, f_relu_q, f_sat_q, f_last_q;
   logic [OW-1:0] f_bias_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fire_q   <= 1'b0;
         f_bias_q <= '0;
         f_relu_q <= 1'b0;
         f_sat_q  <= 1'b0;
         f_last_q <= 1'b0;
      end else begin
         fire_q <= fire;
         if (fire) begin
            f_bias_q <= bias;
            f_relu_q <= relu_en;
            f_sat_q  <= sat_en;
            f_last_q <= last_set;
         end
      end
   end

   // ------------------------------------------------------------------
   // S1: row sums. Taps are read before any write at this edge lands.
   // ------------------------------------------------------------------
   logic [RW-1:0] row_d [K];
   logic [RW-1:0] row_q [K];
   logic          s1_vld_q, s1_relu_q, s1_sat_q, s1_last_q;
   logic [OW-1:0] s1_bias_q;

   always_comb begin
      for (int r = 0; r < K; r++) begin
         row_d[r] = '0;
         for (int c = 0; c < K; c++)
            row_d[r] = row_d[r] + {{(RW-DW){tap_q[r][c][DW-1]}}, tap_q[r][c]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < K; r++) row_q[r] <= '0;
         s1_vld_q  <= 1'b0;
         s1_bias_q <= '0;
         s1_relu_q <= 1'b0;
         s1_sat_q  <= 1'b0;
         s1_last_q <= 1'b0;
      end else begin
         s1_vld_q <= fire_q;
         if (fire_q) begin
            for (int r = 0; r < K; r++) row_q[r] <= row_d[r];
            s1_bias_q <= f_bias_q;
            s1_relu_q <= f_relu_q;
            s1_sat_q  <= f_sat_q;
            s1_last_q <= f_last_q;
         end
      end
   end

   // ------------------------------------------------------------------
   // S2: full-precision total; AW leaves headroom so nothing wraps here
   // ------------------------------------------------------------------
   logic [AW-1:0] sum_d, sum_q;
   logic          s2_vld_q, s2_relu_q, s2_sat_q, s2_last_q;

   always_comb begin
      sum_d = {{(AW-OW){s1_bias_q[OW-1]}}, s1_bias_q};
      for (int r = 0; r < K; r++)
         sum_d = sum_d + {{(AW-RW){row_q[r][RW-1]}}, row_q[r]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q     <= '0;
         s2_vld_q  <= 1'b0;
         s2_relu_q <= 1'b0;
         s2_sat_q  <= 1'b0;
         s2_last_q <= 1'b0;
      end else begin
         s2_vld_q <= s1_vld_q;
         if (s1_vld_q) begin
            sum_q     <= sum_d;
            s2_relu_q <= s1_relu_q;
            s2_sat_q  <= s1_sat_q;
            s2_last_q <= s1_last_q;
         end
      end
   end

   // ------------------------------------------------------------------
   // S3: ReLU, then saturate or wrap to OW bits
   // ------------------------------------------------------------------
   localparam logic [OW-1:0] MAX_V = {1'b0, {(OW-1){1'b1}}};
   localparam logic [OW-1:0] MIN_V = {1'b1, {(OW-1){1'b0}}};

   logic          sum_neg, sum_fits, ovf_d;
   logic [OW-1:0] res_d;
   logic          out_valid_q, out_last_q, out_ovf_q;
   logic [OW-1:0] out_data_q;

   // Representable in OW bits iff all bits from OW-1 upward agree with the sign.
   assign sum_neg  = sum_q[AW-1];
   assign sum_fits = (&sum_q[AW-1:OW-1]) | ~(|sum_q[AW-1:OW-1]);

   always_comb begin
      res_d = sum_q[OW-1:0];
      ovf_d = 1'b0;
      if (s2_relu_q && sum_neg) begin
         res_d = '0;
      end else if (!sum_fits) begin
         ovf_d = 1'b1;
         if (s2_sat_q) res_d = sum_neg ? MIN_V : MAX_V;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_ovf_q   <= 1'b0;
      end else begin
         out_valid_q <= s2_vld_q;
         if (s2_vld_q) begin
            out_data_q <= res_d;
            out_last_q <= s2_last_q;
            out_ovf_q  <= ovf_d;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_ovf   = out_ovf_q;
   assign col_err   = col_err_q;

endmodule

// File: tb/tb_conv_window_accum.sv
// Randomized and directed bench for conv_window_accum against a window-level reference model.
module tb_conv_window_accum;
   localparam int DW = 16;
   localparam int K  = 3;
   localparam int OW = 16;
   localparam int CW = $clog2(K);

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid, in_last, flush, relu_en, sat_en;
   logic [CW-1:0]   in_col;
   logic [K*DW-1:0] in_data;
   logic [OW-1:0]   bias;
   logic            out_valid, out_last, out_ovf, col_err;
   logic [OW-1:0]   out_data;

   conv_window_accum #(.DW(DW), .K(K), .OW(OW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_col(in_col), .in_data(in_data),
      .in_last(in_last), .flush(flush), .bias(bias), .relu_en(relu_en), .sat_en(sat_en),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ovf(out_ovf),
      .col_err(col_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0]   cyc;
      logic [OW-1:0] data;
      logic          last;
      logic          ovf;
   } rec_t;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   rec_t exp_q[$], obs_q[$];
   int   exp_err[$], obs_err[$];

   // Reference model state: window contents, filled columns, pending frame end
   int   m_tap [K][K];
   bit   m_have [K];
   bit   m_lp;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      rec_t o;
      if (out_valid) begin
         o.cyc = 32'(cyc); o.data = out_data; o.last = out_last; o.ovf = out_ovf;
         obs_q.push_back(o);
      end
      if (col_err) obs_err.push_back(cyc);
   end

   function automatic logic [K*DW-1:0] all_lanes(input int x);
      logic [K*DW-1:0] d;
      for (int r = 0; r < K; r++) d[r*DW +: DW] = x[DW-1:0];
      return d;
   endfunction

   task automatic model_clear();
      for (int r = 0; r < K; r++) begin
         m_have[r] = 1'b0;
         for (int c = 0; c < K; c++) m_tap[r][c] = 0;
      end
      m_lp = 1'b0;
   endtask

   task automatic drive(input bit v, input int col, input logic [K*DW-1:0] d, input bit last,
                        input bit fl, input logic signed [OW-1:0] b, input bit re, input bit se);
      bit     all_set;
      longint total, lo, hi;
      logic [63:0] tv;
      rec_t   e;
      @(negedge clk);
      in_valid = v; in_col = col[CW-1:0]; in_data = d; in_last = last;
      flush = fl; bias = b; relu_en = re; sat_en = se;
      if (fl) begin
         for (int c = 0; c < K; c++) m_have[c] = 1'b0;
         m_lp = 1'b0;
      end
      if (v && col >= K) begin
         exp_err.push_back(cyc + 1);
      end else if (v) begin
         for (int r = 0; r < K; r++) m_tap[r][col] = $signed(d[r*DW +: DW]);
         m_have[col] = 1'b1;
         if (last) m_lp = 1'b1;
         all_set = 1'b1;
         for (int c = 0; c < K; c++) if (!m_have[c]) all_set = 1'b0;
         if (all_set) begin
            total = b;
            for (int r = 0; r < K; r++)
               for (int c = 0; c < K; c++) total += m_tap[r][c];
            lo = -(longint'(1) << (OW-1));
            hi = (longint'(1) << (OW-1)) - 1;
            tv = total;
            e.cyc = 32'(cyc + 4); e.last = m_lp; e.ovf = 1'b0; e.data = tv[OW-1:0];
            if (re && total < 0) begin
               e.data = '0;
            end else if (total > hi || total < lo) begin
               e.ovf = 1'b1;
               if (se) begin
                  tv = (total > hi) ? hi : lo;
                  e.data = tv[OW-1:0];
               end
            end
            exp_q.push_back(e);
            for (int c = 0; c < K; c++) m_have[c] = 1'b0;
            m_lp = 1'b0;
         end
      end
   endtask

   task automatic wr(input int col, input int lane, input bit last = 1'b0, input int b = 0,
                     input bit re = 1'b0, input bit se = 1'b1);
      drive(1'b1, col, all_lanes(lane), last, 1'b0, b[OW-1:0], re, se);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic clear_q();
      exp_q.delete(); obs_q.delete(); exp_err.delete(); obs_err.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_col = '0; in_data = '0; in_last = 1'b0;
      flush = 1'b0; bias = '0; relu_en = 1'b0; sat_en = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      n_chk++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      n_chk++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
      n_chk++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL reset_out_ovf got=%b exp=0", out_ovf); end
      n_chk++; if (col_err !== 1'b0) begin n_err++; $display("FAIL reset_col_err got=%b exp=0", col_err); end
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_single_window();
      clear_q();
      wr(0, 1, 0, 5); wr(1, 1, 0, 5); wr(2, 1, 0, 5);
      idle(6);
      n_chk++;
      if (obs_q.size() != 1 || obs_q[0].data !== 16'd14 || obs_q[0].ovf !== 1'b0) begin
         n_err++; $display("FAIL single_value got n=%0d data=%h exp n=1 data=000e ovf=0", obs_q.size(), out_data);
      end
      n_chk++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL single_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_chk++;
         if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL single_out%0d got=%h exp=%h (cyc,data,last,ovf)", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_order_overwrite();
      clear_q();
      wr(2, 10); wr(0, 1); wr(2, 3);
      idle(5);
      n_chk++; if (obs_q.size() != 0) begin n_err++; $display("FAIL order_early got=%0d outputs exp=0", obs_q.size()); end
      wr(1, 2);
      idle(6);
      n_chk++;
      if (obs_q.size() != 1 || obs_q[0].data !== 16'd18) begin
         n_err++; $display("FAIL order_value got n=%0d data=%h exp n=1 data=0012", obs_q.size(), out_data);
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_chk++;
         if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL order_out%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_saturation();
      clear_q();
      for (int c = 0; c < K; c++) wr(c, 32767, 0, 0, 0, 1);
      idle(5);
      for (int c = 0; c < K; c++) wr(c, 32767, 0, 0, 0, 0);
      idle(6);
      n_chk++;
      if (obs_q.size() != 2 || obs_q[0].data !== 16'h7FFF || obs_q[0].ovf !== 1'b1) begin
         n_err++; $display("FAIL sat_clamp got n=%0d exp 7fff ovf=1", obs_q.size());
      end
      n_chk++;
      if (obs_q.size() != 2 || obs_q[1].data !== 16'h7FF7 || obs_q[1].ovf !== 1'b1) begin
         n_err++; $display("FAIL sat_wrap got n=%0d data=%h exp 7ff7 ovf=1", obs_q.size(), out_data);
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_chk++;
         if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL sat_out%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_relu();
      clear_q();
      for (int c = 0; c < K; c++) wr(c, -2, 0, 3, 1, 1);
      idle(5);
      for (int c = 0; c < K; c++) wr(c, -2, 0, 3, 0, 1);
      idle(6);
      n_chk++;
      if (obs_q.size() != 2 || obs_q[0].data !== 16'h0000 || obs_q[0].ovf !== 1'b0) begin
         n_err++; $display("FAIL relu_on got n=%0d exp data=0000 ovf=0", obs_q.size());
      end
      n_chk++;
      if (obs_q.size() != 2 || obs_q[1].data !== 16'hFFF1) begin
         n_err++; $display("FAIL relu_off got n=%0d data=%h exp fff1", obs_q.size(), out_data);
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_chk++;
         if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL relu_out%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_back_to_back();
      clear_q();
      wr(0, 1); wr(1, 1); wr(2, 1); wr(0, 2, 1); wr(1, 2); wr(2, 2);
      idle(6);
      n_chk++;
      if (obs_q.size() != 2 || obs_q[1].cyc - obs_q[0].cyc != 3) begin
         n_err++; $display("FAIL b2b_spacing got n=%0d exp 2 pulses 3 apart", obs_q.size());
      end
      n_chk++;
      if (obs_q.size() != 2 || obs_q[0].last !== 1'b0 || obs_q[1].last !== 1'b1) begin
         n_err++; $display("FAIL b2b_last got n=%0d exp last=0 then 1", obs_q.size());
      end
      n_chk++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL b2b_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_chk++;
         if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_out%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
      end
      clear_q();
      wr(0, 9); wr(1, 9);
      drive(1'b0, 0, '0, 1'b0, 1'b1, '0, 1'b0, 1'b0);
      wr(0, 2); wr(1, 2); wr(2, 2);
      idle(6);
      n_chk++;
      if (obs_q.size() != 1 || obs_q[0].data !== 16'd18) begin
         n_err++; $display("FAIL flush_value got n=%0d data=%h exp n=1 data=0012", obs_q.size(), out_data);
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_chk++;
         if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL flush_out%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_illegal_col();
      clear_q();
      wr(0, 1); wr(1, 1); wr(3, 100);
      idle(5);
      n_chk++; if (obs_q.size() != 0) begin n_err++; $display("FAIL illegal_output got=%0d outputs exp=0", obs_q.size()); end
      n_chk++;
      if (obs_err.size() != 1 || exp_err.size() != 1 || obs_err[0] != exp_err[0]) begin
         n_err++; $display("FAIL illegal_col_err got %0d pulses exp 1 at cyc %0d", obs_err.size(), exp_err.size() ? exp_err[0] : -1);
      end
      wr(2, 1);
      idle(6);
      n_chk++;
      if (obs_q.size() != 1 || obs_q[0].data !== 16'd9) begin
         n_err++; $display("FAIL illegal_taps got n=%0d data=%h exp n=1 data=0009", obs_q.size(), out_data);
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_chk++;
         if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL illegal_out%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_random();
      logic [K*DW-1:0] d;
      int lane;
      clear_q();
      for (int n = 0; n < 400; n++) begin
         bit big;
         big = ($urandom_range(1, 0) == 1);
         for (int r = 0; r < K; r++) begin
            lane = big ? int'($urandom) : int'($urandom_range(20, 0)) - 10;
            d[r*DW +: DW] = lane[DW-1:0];
         end
         lane = int'($urandom);
         drive(($urandom_range(3, 0) != 0), int'($urandom_range(3, 0)), d,
               ($urandom_range(4, 0) == 0), ($urandom_range(15, 0) == 0),
               lane[OW-1:0], $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1);
      end
      idle(6);
      n_chk++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_chk++;
         if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_out%0d got=%h exp=%h (cyc,data,last,ovf)", i, obs_q[i], exp_q[i]); end
      end
      n_chk++; if (obs_err != exp_err) begin n_err++; $display("FAIL rand_col_err got %0d pulses exp %0d", obs_err.size(), exp_err.size()); end
   endtask

   task automatic test_reset_mid();
      drive(1'b0, 0, '0, 1'b0, 1'b1, '0, 1'b0, 1'b0);
      for (int c = 0; c < K; c++) wr(c, 7, 0, 1);
      idle(5);
      clear_q();
      for (int c = 0; c < K; c++) wr(c, 4);
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0;
      clear_q();
      model_clear();
      repeat (2) @(negedge clk);
      n_chk++; if (out_data !== '0) begin n_err++; $display("FAIL rstmid_data got=%h exp=0", out_data); end
      rst_n = 1'b1;
      idle(6);
      n_chk++; if (obs_q.size() != 0) begin n_err++; $display("FAIL rstmid_valid got=%0d outputs exp=0", obs_q.size()); end
      n_chk++;
      if ({out_valid, out_data, out_last, out_ovf, col_err} !== '0) begin
         n_err++; $display("FAIL rstmid_outputs got v=%b d=%h l=%b o=%b e=%b exp all 0", out_valid, out_data, out_last, out_ovf, col_err);
      end
   endtask

   initial begin
      test_reset();
      test_single_window();
      test_order_overwrite();
      test_saturation();
      test_relu();
      test_back_to_back();
      test_illegal_col();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/conv_window_accum.md
# conv_window_accum

Parametrised K×K window accumulator for the convolution datapath. Collects one column of K partial products per write into a K×K tap array. Once every column has been written, it launches a 3-stage pipelined adder tree that adds all K·K taps plus a bias. The result then passes through optional ReLU and saturation and is emitted with a one-cycle valid strobe and a frame-end flag.

## Interface
- DW, 16: signed width of each input lane (two's complement)
- K, 3: window dimension (lanes per write and columns per window); legal range 2..8
- OW, 16: signed width of bias and of out_data
- CW, $clog2(K): width of in_col (derived; do not override)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  column write strobe
- in_col  in  CW  column index for the write
- in_data  in  K·DW  lane r = in_data[r·DW +: DW], written to tap[r][in_col]
- in_last  in  1  frame-end marker
- flush  in  1  synchronous discard of the partially filled window
- bias  in  OW  signed bias, sampled on the completing write
- relu_en  in  1  clamp negative results to 0, sampled on the completing write
- sat_en  in  1  saturate (1) or wrap (0), sampled on the completing write
- out_valid  out  1  result strobe, exactly one cycle per window
- out_data  out  OW  post-processed result, valid only with out_valid
- out_last  out  1  frame-end flag, qualified by out_valid
- out_ovf  out  1  result was clamped or wrapped, qualified by out_valid
- col_err  out  1  one-cycle pulse the cycle after a write with in_col ≥ K

## Operation
- **Column write.** On in_valid with in_col < K: tap[r][in_col] ← lane r for every r, and mask[in_col] ← 1. Rewriting an already-written column overwrites its taps and raises no error.
- **Illegal column.** A write with in_col ≥ K changes no tap or mask bit. col_err pulses the next cycle.
- **Frame-end marker.** in_last on any legal write sets last_pend. last_pend travels with the next completed window and is then cleared.
- **Completion.** The write that makes mask all-ones is the fire event. On that edge:
  - fire_q is set;
  - mask is cleared;
  - bias, relu_en, sat_en and (last_pend | in_last) are captured into the pipeline.
- **Pipeline stages.**
  - S1: K row sums, each DW+CW+1 bits signed.
  - S2: total of the row sums plus sign-extended bias, held at full precision with AW = max(DW+2·CW+2, OW)+1 bits. No internal overflow is possible.
  - S3 (post-processing):
    - if relu_en and the total is negative, the result is 0;
    - otherwise, if sat_en, clamp to [−2^(OW−1), 2^(OW−1)−1];
    - otherwise keep the low OW bits (wrap).
  - out_ovf = 1 whenever the pre-clamp value is not representable in OW bits and ReLU did not zero it.
- **Flush.** Clears mask and last_pend. Windows already in S1–S3 complete normally. A write in the same cycle as flush wins: it sets its own mask bit after the clear.
- **Reset.** Asynchronous. Clears every tap, mask, last_pend, every pipeline valid and data register, and all outputs. In-flight windows are lost.

## Timing
- **Reset values.** out_valid=0, out_data=0, out_last=0, out_ovf=0, col_err=0.
- **Latency.** Completing write sampled at edge N → fire_q at N → S1 at N+1 → S2 at N+2 → out_valid high after edge N+3 for one cycle.
- **Tap reads.** S1 samples taps before the edge at which any new write updates them. A write in cycle N+1 therefore does not corrupt the window in flight.
- **Throughput.** One window per K cycles (one column per write). Back-to-back windows never stall or drop; no backpressure exists.
- **out_data hold.** out_data holds its last value when out_valid=0; the verifier checks it only with out_valid.
- **Same-edge fire and in_last.** in_last on the completing write itself is carried with that window. last_pend is not left set afterwards.

## Test plan
- **Single window.** K=3, DW=16. Write cols 0,1,2 on consecutive cycles with every lane 1 and bias=5 → one out_valid three cycles after the col-2 write, out_data=14, out_ovf=0.
- **Order and overwrite.** Write col order 2,0,2,1 (lanes 10, then 1, then 3, then 2; the second col-2 write overwrites the first), bias=0 → out_data=18 emitted after the col-1 write only.
- **Saturation vs. wrap.** OW=16, all lanes 32767, bias=0:
  - sat_en=1 → out_data=32767, out_ovf=1;
  - sat_en=0 → out_data = low 16 bits of 294903 = 0x7FF7, out_ovf=1.
- **ReLU.** All lanes −2, bias=3, relu_en=1 → out_data=0, out_ovf=0. Same with relu_en=0 → out_data=−15.
- **Back-to-back, frame end and flush.**
  - Two windows in 6 consecutive writes, in_last on the 4th write → two out_valid pulses 3 cycles apart; out_last only on the second.
  - flush after 2 writes, then 3 fresh writes → exactly one output, from the fresh data.
- **Illegal column and reset.**
  - in_col=3 → col_err pulse; no tap change and no output.
  - Assert rst_n low mid-pipeline (one cycle after the completing write) → no out_valid after release; all outputs 0.
